// File: rtl/xfer_ctrl_fsm_pkg.sv
// Shared types and constants for the register-transfer control FSM:
// state encoding, opcodes and instruction field positions.
package xfer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M_OUT = 4'd1,
        ST_M_IN  = 4'd2,
        ST_S1    = 4'd3,
        ST_S2    = 4'd4,
        ST_S3    = 4'd5,
        ST_S4    = 4'd6,
        ST_S5    = 4'd7,
        ST_S6    = 4'd8,
        ST_DONE  = 4'd9,
        ST_ERR   = 4'd10
    } state_e;

    localparam logic [3:0] OPC_MOV_DEF = 4'b0110;
    localparam logic [3:0] OPC_SWP_DEF = 4'b0111;

    localparam int OPC_LSB = 12;
    localparam int OPC_W   = 4;
    localparam int P1_LSB  = 6;
    localparam int P2_LSB  = 0;

endpackage

// File: rtl/xfer_ctrl_fsm_if.sv
// Decoder-side request and register-bus control signals of the transfer FSM.
interface xfer_ctrl_fsm_if #(
    parameter int NUM_REGS = 5,
    parameter int INSTR_W  = 16
);
    logic                start;
    logic [INSTR_W-1:0]  instr;
    logic                busy;
    logic                pc_inc;
    logic [NUM_REGS-1:0] reg_out_en;
    logic [NUM_REGS-1:0] reg_in_en;
    logic                tmp_out;
    logic                tmp_in;
    logic                done;
    logic                err;

    modport master (
        output start, instr,
        input  busy, pc_inc, reg_out_en, reg_in_en, tmp_out, tmp_in, done, err
    );

    modport slave (
        input  start, instr,
        output busy, pc_inc, reg_out_en, reg_in_en, tmp_out, tmp_in, done, err
    );
endinterface

// File: rtl/xfer_ctrl_fsm_sel_onehot_dec.sv
// Operand selector to one-hot register enable, with a range flag for
// selectors that address no attached register.
module sel_onehot_dec #(
    parameter int NUM_REGS = 5,
    parameter int SEL_W    = 6
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot,
    output logic                o_in_range
);

    always_comb begin
        o_onehot   = '0;
        o_in_range = (int'(i_sel) < NUM_REGS);
        for (int k = 0; k < NUM_REGS; k++) begin
            o_onehot[k] = i_en && (int'(i_sel) == k);
        end
    end

endmodule

// File: rtl/xfer_ctrl_fsm.sv
// MOV / SWAP register-transfer controller: latches an instruction on start
// and sequences one-hot bus enables, pc_inc and done/err pulses.
module xfer_ctrl_fsm
    import xfer_pkg::*;
#(
    parameter int         NUM_REGS = 5,
    parameter int         INSTR_W  = 16,
    parameter int         SEL_W    = 6,
    parameter logic [3:0] OPC_MOV  = OPC_MOV_DEF,
    parameter logic [3:0] OPC_SWP  = OPC_SWP_DEF
) (
    input logic clk,
    input logic rst,
    xfer_ctrl_fsm_if.slave bus
);

    state_e              r_state;
    state_e              w_next;
    logic [SEL_W-1:0]    r_p1;
    logic [SEL_W-1:0]    r_p2;
    logic [OPC_W-1:0]    w_opc;
    logic [SEL_W-1:0]    w_p1_sel;
    logic [SEL_W-1:0]    w_p2_sel;
    logic                w_accept;
    logic                w_active;
    logic                w_p1_ok;
    logic                w_p2_ok;
    logic [NUM_REGS-1:0] w_p1_oh;
    logic [NUM_REGS-1:0] w_p2_oh;

    assign w_opc    = bus.instr[OPC_LSB +: OPC_W];
    assign w_accept = bus.start && ((w_opc == OPC_MOV) || (w_opc == OPC_SWP));
    assign w_active = (r_state != ST_IDLE);

    // In IDLE the decoders look at the incoming fields for the range check;
    // their one-hot outputs are gated off there, so instr never reaches an output.
    assign w_p1_sel = w_active ? r_p1 : bus.instr[P1_LSB +: SEL_W];
    assign w_p2_sel = w_active ? r_p2 : bus.instr[P2_LSB +: SEL_W];

    sel_onehot_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_p1 (
        .i_sel      (w_p1_sel),
        .i_en       (w_active),
        .o_onehot   (w_p1_oh),
        .o_in_range (w_p1_ok)
    );

    sel_onehot_dec #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_dec_p2 (
        .i_sel      (w_p2_sel),
        .i_en       (w_active),
        .o_onehot   (w_p2_oh),
        .o_in_range (w_p2_ok)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_p1    <= '0;
            r_p2    <= '0;
        end else begin
            r_state <= w_next;
            if (!w_active && w_accept) begin
                r_p1 <= bus.instr[P1_LSB +: SEL_W];
                r_p2 <= bus.instr[P2_LSB +: SEL_W];
            end
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.busy       = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.reg_out_en = '0;
        bus.reg_in_en  = '0;
        bus.tmp_out    = 1'b0;
        bus.tmp_in     = 1'b0;
        bus.done       = 1'b0;
        bus.err        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (!(w_p1_ok && w_p2_ok)) w_next = ST_ERR;
                    else if (w_opc == OPC_MOV) w_next = ST_M_OUT;
                    else                       w_next = ST_S1;
                end
            end
            ST_M_OUT: begin
                bus.busy = 1'b1; bus.pc_inc = 1'b1; bus.reg_out_en = w_p2_oh;
                w_next = ST_M_IN;
            end
            ST_M_IN: begin
                bus.busy = 1'b1; bus.reg_in_en = w_p1_oh;
                w_next = ST_DONE;
            end
            ST_S1: begin
                bus.busy = 1'b1; bus.pc_inc = 1'b1; bus.reg_out_en = w_p1_oh;
                w_next = ST_S2;
            end
            ST_S2: begin
                bus.busy = 1'b1; bus.tmp_in = 1'b1;
                w_next = ST_S3;
            end
            ST_S3: begin
                bus.busy = 1'b1; bus.reg_out_en = w_p2_oh;
                w_next = ST_S4;
            end
            ST_S4: begin
                bus.busy = 1'b1; bus.reg_in_en = w_p1_oh;
                w_next = ST_S5;
            end
            ST_S5: begin
                bus.busy = 1'b1; bus.tmp_out = 1'b1;
                w_next = ST_S6;
            end
            ST_S6: begin
                bus.busy = 1'b1; bus.reg_in_en = w_p2_oh;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                bus.busy = 1'b1; bus.done = 1'b1;
                w_next = ST_IDLE;
            end
            ST_ERR: begin
                bus.busy = 1'b1; bus.err = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_xfer_ctrl_fsm.sv
// Bench for xfer_ctrl_fsm: a transaction-level model expands each accepted
// instruction into its expected per-cycle output list.
module tb_xfer_ctrl_fsm;

    localparam int NR = 5;

    typedef struct packed {
        logic          busy;
        logic          pc;
        logic [NR-1:0] oe;
        logic [NR-1:0] ie;
        logic          to;
        logic          ti;
        logic          dn;
        logic          er;
    } snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    snap_t exp_q[$];
    snap_t cur = '0;
    snap_t obs;

    xfer_ctrl_fsm_if #(.NUM_REGS(NR), .INSTR_W(16)) tb_if ();

    xfer_ctrl_fsm #(.NUM_REGS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tb_if.slave)
    );

    always #5 clk = ~clk;

    function automatic snap_t get_obs();
        snap_t s;
        s.busy = tb_if.busy;    s.pc = tb_if.pc_inc;
        s.oe   = tb_if.reg_out_en; s.ie = tb_if.reg_in_en;
        s.to   = tb_if.tmp_out; s.ti = tb_if.tmp_in;
        s.dn   = tb_if.done;    s.er = tb_if.err;
        return s;
    endfunction

    function automatic snap_t mk(input logic pc, input logic [NR-1:0] oe, input logic [NR-1:0] ie,
                                 input logic to, input logic ti, input logic dn, input logic er);
        snap_t s;
        s.busy = 1'b1; s.pc = pc; s.oe = oe; s.ie = ie;
        s.to = to; s.ti = ti; s.dn = dn; s.er = er;
        return s;
    endfunction

    function automatic bit legal_opc(input logic [15:0] ins);
        return (ins[15:12] == 4'b0110) || (ins[15:12] == 4'b0111);
    endfunction

    // Expected cycle-by-cycle behaviour of one accepted instruction.
    function automatic void push_seq(input logic [15:0] ins);
        int p1, p2;
        logic [NR-1:0] a, b;
        p1 = int'(ins[11:6]);
        p2 = int'(ins[5:0]);
        if (p1 >= NR || p2 >= NR) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1));
            return;
        end
        a = NR'(1) << p1;
        b = NR'(1) << p2;
        if (ins[15:12] == 4'b0110) begin
            exp_q.push_back(mk(1, b, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, a, 0, 0, 0, 0));
        end else begin
            exp_q.push_back(mk(1, a, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 0));
            exp_q.push_back(mk(0, b, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, a, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0));
            exp_q.push_back(mk(0, 0, b, 0, 0, 0, 0));
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle at negedge.
    task automatic tick(input logic s, input logic [15:0] ins);
        tb_if.start = s;
        tb_if.instr = ins;
        @(posedge clk);
        if (!cur.busy && s && legal_opc(ins)) push_seq(ins);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        obs = get_obs();
        checks++;
        if (obs !== '0) begin
            errors++; $display("FAIL reset_state got %h want %h", obs, 16'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(0, 16'h0);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL reset_idle got %h want %h", obs, cur); end
        end
    endtask

    task automatic test_mov();
        logic [15:0] want_oe [3];
        want_oe = '{16'h0008, 16'h0000, 16'h0000};
        for (int i = 0; i < 5; i++) begin
            tick(i == 0, 16'h6083);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL mov_c%0d got %h want %h", i + 1, obs, cur); end
            if (i < 3) begin
                checks++;
                if ({11'b0, obs.oe} !== want_oe[i] || obs.busy !== 1'b1) begin
                    errors++; $display("FAIL mov_lit_c%0d got oe=%b busy=%b want oe=%h busy=1", i + 1, obs.oe, obs.busy, want_oe[i]);
                end
            end
        end
    endtask

    task automatic test_swap();
        for (int i = 0; i < 9; i++) begin
            tick(i == 0, 16'h7004);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL swap_c%0d got %h want %h", i + 1, obs, cur); end
        end
        checks++;
        if (cur.busy !== 1'b0) begin errors++; $display("FAIL swap_end got busy=%b want 0", cur.busy); end
    endtask

    task automatic test_err_and_ignore();
        for (int i = 0; i < 3; i++) begin
            tick(i == 0, 16'h6005);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL err_c%0d got %h want %h", i + 1, obs, cur); end
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 16'h3083);
            obs = get_obs(); checks++;
            if (obs !== '0) begin errors++; $display("FAIL bad_opc_c%0d got %h want 0", i + 1, obs); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq_in [8];
        logic        seq_st [8];
        // MOV, start during M_IN (ignored), start during DONE (ignored), start in IDLE (accepted)
        seq_in = '{16'h6083, 16'h0000, 16'h7004, 16'h6042, 16'h6042, 16'h0000, 16'h0000, 16'h0000};
        seq_st = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b0};
        for (int i = 0; i < 8; i++) begin
            tick(seq_st[i], seq_in[i]);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL b2b_c%0d got %h want %h", i + 1, obs, cur); end
        end
    endtask

    task automatic test_reset_mid_swap();
        for (int i = 0; i < 3; i++) begin
            tick(i == 0, 16'h7004);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL rst_pre_c%0d got %h want %h", i + 1, obs, cur); end
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        cur = '0;
        obs = get_obs(); checks++;
        if (obs !== '0) begin errors++; $display("FAIL rst_mid_swap got %h want 0", obs); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(i == 1, 16'h6083);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL rst_post_c%0d got %h want %h", i + 1, obs, cur); end
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        logic [3:0]  opc;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    opc = 4'b0110;
                2, 3:    opc = 4'b0111;
                default: opc = 4'($urandom_range(0, 15));
            endcase
            ins = {opc, 6'($urandom_range(0, 6)), 6'($urandom_range(0, 6))};
            if ($urandom_range(0, 19) == 0) ins[11:6] = 6'($urandom_range(0, 63));
            tick(1'($urandom_range(0, 1)), ins);
            obs = get_obs(); checks++;
            if (obs !== cur) begin errors++; $display("FAIL rand_c%0d got %h want %h ins %h", i, obs, cur, ins); end
        end
    endtask

    initial begin
        tb_if.start = 1'b0;
        tb_if.instr = '0;
        #2;
        test_reset();
        test_mov();
        test_swap();
        test_err_and_ignore();
        test_back_to_back();
        test_reset_mid_swap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xfer_ctrl_fsm.md
Name: xfer_ctrl_fsm

Overview:
Parametrised register-transfer control FSM, the next-generation successor of the single-opcode MOV controller. It accepts a latched instruction on a start pulse and executes MOV (src→dst) or SWAP (A↔B via temp register). It drives one-hot bus out/in enables for NUM_REGS registers plus a temp register, pc_inc, and done/err pulses. It sits between the instruction decoder and the shared register bus in the microcontroller datapath.

Parameters:
NUM_REGS, 5, number of bus-attached registers; selector value k drives enable bit k (k < NUM_REGS).
INSTR_W, 16, instruction width.
SEL_W, 6, width of each operand field.
OPC_MOV, 4'b0110, opcode for MOV.
OPC_SWP, 4'b0111, opcode for SWAP.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
instr  input  INSTR_W  [15:12] opcode, [11:6] p1 (dst / A), [5:0] p2 (src / B); latched on accepted start.
busy  output  1  high from the first cycle after an accepted start through the DONE/ERR cycle inclusive.
pc_inc  output  1  one-cycle PC increment request.
reg_out_en  output  NUM_REGS  one-hot (or zero) register-drives-bus enables.
reg_in_en  output  NUM_REGS  one-hot (or zero) register-loads-bus enables.
tmp_out  output  1  temp register drives bus.
tmp_in  output  1  temp register loads bus.
done  output  1  one-cycle completion pulse.
err  output  1  one-cycle pulse on illegal operand.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; latched instruction cleared. Reset mid-operation aborts immediately, with no further enables.
- Outputs are a pure decode of the registered state and latched operands. No combinational path from start/instr to any output.
- At most one of {reg_out_en bits, tmp_out} is high per cycle; likewise for {reg_in_en bits, tmp_in}. An out enable and an in enable are never high in the same cycle.
- IDLE, start=1:
  - opcode == OPC_MOV or OPC_SWP: latch instr. If p1 or p2 >= NUM_REGS, go to ERR; otherwise go to the first transfer state.
  - any other opcode: start ignored; stay IDLE, no outputs.
- MOV sequence (one state per cycle):
  - M_OUT: reg_out_en[p2]=1, pc_inc=1.
  - M_IN: reg_in_en[p1]=1.
  - DONE: done=1.
  - then IDLE.
- SWAP sequence:
  - S1: reg_out_en[p1]=1, pc_inc=1.
  - S2: tmp_in=1.
  - S3: reg_out_en[p2]=1.
  - S4: reg_in_en[p1]=1.
  - S5: tmp_out=1.
  - S6: reg_in_en[p2]=1.
  - DONE: done=1.
  - then IDLE.
- ERR: err=1 for one cycle, pc_inc=0, no enables; then IDLE.
- Latency (start accepted at edge 0):
  - MOV: done at cycle 3.
  - SWAP: done at cycle 7.
  - ERR: err at cycle 1.
  - Next start is accepted at the cycle after DONE/ERR, i.e. back-to-back with a one-cycle IDLE gap.
- start while busy: ignored; instr changes while busy have no effect.
- p1 == p2: sequence executes normally (MOV is a self-copy, SWAP leaves data unchanged); no err.
- Unreachable state encodings go to IDLE with all outputs 0.

Decomposition:
- Shared package xfer_pkg holds:
  - state enum: IDLE, M_OUT, M_IN, S1..S6, DONE, ERR (4-bit);
  - opcode localparams;
  - instruction field positions.
- Sub-module sel_onehot_dec: SEL_W selector + enable → NUM_REGS one-hot vector plus in_range flag. Instantiate twice, once per operand field.

Test Plan:
- Reset mid-SWAP: assert rst during S3 → all outputs 0 that cycle; IDLE after release; next MOV works.
- MOV with NUM_REGS=5, instr=16'h6083 (p1=2, p2=3), start pulse:
  - cycle 1: reg_out_en=5'b01000, pc_inc=1;
  - cycle 2: reg_in_en=5'b00100;
  - cycle 3: done=1;
  - busy high cycles 1–3.
- SWAP, instr=16'h7004 (p1=0, p2=4): cycles 1–6 give out[0]+pc_inc, tmp_in, out[4], in[0], tmp_out, in[4]; done at cycle 7.
- Illegal operand, instr=16'h6005 (p2=5): err=1 at cycle 1; no enables, no pc_inc, no done.
- Non-matching opcode 16'h3083 with start → busy and all outputs stay 0.
- Second start asserted during MOV cycle 2 → ignored. Back-to-back start at the cycle after done → accepted, with the correct sequence.
